// File: rtl/phy_buf_pkg.sv
// Shared constants for the PHY output buffer: default geometry and the drop-counter ceiling.
package phy_buf_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_AF_LEVEL   = 6;

  localparam logic [7:0] ERRCNT_MAX = 8'd255;

  // Saturating increment used by the optional drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    if (val == ERRCNT_MAX) begin
      return val;
    end else begin
      return val + 8'd1;
    end
  endfunction

endpackage

// File: rtl/phy_out_buffer_if.sv
// Data/handshake bundle between the PHY receive path, the output buffer and its consumer.
// err_count is present only when PHY_OUT_BUF_ERRCNT_EN is defined.
interface phy_out_buffer_if #(
  parameter int DATA_WIDTH = phy_buf_pkg::DEF_DATA_WIDTH,
  parameter int DEPTH      = phy_buf_pkg::DEF_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_in;
  logic                  ovf_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  overflow;
  logic [CW-1:0]         count;
`ifdef PHY_OUT_BUF_ERRCNT_EN
  logic [7:0]            err_count;

  modport master (
    output data_in, valid_in, ready_in, ovf_clr,
    input  data_out, valid_out, fifo_empty, almost_full, overflow, count, err_count
  );
  modport slave (
    input  data_in, valid_in, ready_in, ovf_clr,
    output data_out, valid_out, fifo_empty, almost_full, overflow, count, err_count
  );
`else
  modport master (
    output data_in, valid_in, ready_in, ovf_clr,
    input  data_out, valid_out, fifo_empty, almost_full, overflow, count
  );
  modport slave (
    input  data_in, valid_in, ready_in, ovf_clr,
    output data_out, valid_out, fifo_empty, almost_full, overflow, count
  );
`endif

endinterface

// File: rtl/phy_out_mem.sv
// Buffer storage: synchronous write, asynchronous read, contents deliberately not reset.
module phy_out_mem
  import phy_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                     clk_f,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write port.
  always_ff @(posedge clk_f) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/phy_out_buffer.sv
// PHY output buffer: pointer/flag control around phy_out_mem, sticky overflow on dropped words.
// Optional drop counter err_count enabled by defining PHY_OUT_BUF_ERRCNT_EN.
module phy_out_buffer
  import phy_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL
) (
  input logic             clk_f,
  input logic             reset,
  phy_out_buffer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_count;
  logic                  r_fifo_empty;
  logic                  r_almost_full;
  logic                  r_overflow;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_drop;
  logic [PW-1:0]         w_wr_ptr_nxt;
  logic [PW-1:0]         w_rd_ptr_nxt;
  logic [PW-1:0]         w_count_nxt;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Handshake decode; a read frees a slot so a write into a full buffer still lands.
  always_comb begin
    w_empty      = (r_wr_ptr == r_rd_ptr);
    w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_rd         = !w_empty && bus.ready_in;
    w_wr         = bus.valid_in && (!w_full || w_rd);
    w_drop       = bus.valid_in && !w_wr;
    w_wr_ptr_nxt = w_wr ? (r_wr_ptr + PW'(1'b1)) : r_wr_ptr;
    w_rd_ptr_nxt = w_rd ? (r_rd_ptr + PW'(1'b1)) : r_rd_ptr;
    w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
  end

  // Pointers, occupancy and flags; set beats clear on the sticky overflow.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_wr_ptr      <= {PW{1'b0}};
      r_rd_ptr      <= {PW{1'b0}};
      r_count       <= {PW{1'b0}};
      r_fifo_empty  <= 1'b1;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_fifo_empty  <= (w_count_nxt == {PW{1'b0}});
      r_almost_full <= (w_count_nxt >= PW'(AF_LEVEL));
      r_overflow    <= w_drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : r_overflow);
    end
  end

  phy_out_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_f   (clk_f),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (bus.data_in),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.data_out    = w_rdata;
  assign bus.valid_out   = !r_fifo_empty;
  assign bus.fifo_empty  = r_fifo_empty;
  assign bus.almost_full = r_almost_full;
  assign bus.overflow    = r_overflow;
  assign bus.count       = r_count;

`ifdef PHY_OUT_BUF_ERRCNT_EN
  logic [7:0] r_err_count;

  // Drop counter: a drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_err_count <= 8'd0;
    end else if (w_drop) begin
      r_err_count <= bus.ovf_clr ? 8'd1 : sat_inc8(r_err_count);
    end else if (bus.ovf_clr) begin
      r_err_count <= 8'd0;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  assign bus.err_count = r_err_count;
`endif

endmodule
